// File: rtl/tos_alu_pkg.sv
// Shared definitions for the multi-cycle TOS arithmetic unit.
//   op_e    : operation encodings presented on the op port
//   state_e : FSM state encodings (also exported for observation)
package tos_alu_pkg;

  typedef enum logic [1:0] {
    OP_UMUL    = 2'b00,
    OP_UDIVMOD = 2'b01,
    OP_SHL     = 2'b10,
    OP_ASHR    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_e;

endpackage

// File: rtl/tos_seq_alu_if.sv
// Request/result bundle between the stack core and tos_seq_alu.
//   start, op, TOS, arg         : request (core -> unit)
//   busy, done, result_lo/hi,err: status/results (unit -> core)
//   state                       : FSM state, observation only
// Handshake: a request is accepted on a clk edge where start=1 and the unit
// is idle (busy=0); start at any other time is dropped, never queued. busy
// rises after the accepting edge; done pulses for one cycle when results and
// err are written, and they then hold until the next accepted request writes
// them again. Request inputs may change freely after acceptance.
interface tos_seq_alu_if
  import tos_alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] TOS;
  logic [WIDTH-1:0] arg;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             err;
  state_e           state;

  modport master (
    output start, op, TOS, arg,
    input  busy, done, result_lo, result_hi, err, state
  );

  modport slave (
    input  start, op, TOS, arg,
    output busy, done, result_lo, result_hi, err, state
  );
endinterface

// File: rtl/tos_seq_step.sv
// One iteration of the iterative datapath, purely combinational.
// Optional feature macro: TOS_SEQ_ALU_DIV_EN builds the restoring divider.
// Ports:
//   op_i      : operation in flight
//   acc_i     : 2*WIDTH accumulator {hi, lo}
//   mcand_i   : multiplicand (UMUL)
//   divisor_i : divisor (UDIVMOD)
//   acc_o     : accumulator after one iteration
module tos_seq_step
  import tos_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e                  op_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     divisor_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_trial;

  // Shift-add: hi accumulates the multiplicand when the multiplier LSB
  // (acc[0]) is set; the carry lands in the top bit as the pair shifts right.
  assign mul_sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};

  // Restoring divide: partial remainder (hi) gains the next dividend bit.
  assign div_shift = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};

`ifdef TOS_SEQ_ALU_DIV_EN
  assign div_trial = div_shift - {1'b0, divisor_i};
`else
  logic unused_div;
  assign unused_div = ^{divisor_i, div_shift};
  assign div_trial  = '0;
`endif

  always_comb begin
    acc_o = acc_i;
    case (op_i)
      OP_UMUL: begin
        if (acc_i[0]) acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        else          acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
      OP_UDIVMOD: begin
`ifdef TOS_SEQ_ALU_DIV_EN
        // Non-negative trial means the divisor fits: keep it, quotient bit 1.
        if (!div_trial[WIDTH])
          acc_o = {div_trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        else
          acc_o = {div_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
`else
        acc_o = acc_i;
`endif
      end
      OP_SHL:  acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], 1'b0};
      OP_ASHR: acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/tos_seq_alu.sv
// Multi-cycle arithmetic unit beside the stack core's TOS path: iterative
// unsigned multiply, unsigned divide/modulo, and multi-bit shifts on
// (arg, TOS). busy feeds the core's wait_state.
// Optional feature macro: TOS_SEQ_ALU_DIV_EN (op 01 performs UDIVMOD; when
// undefined op 01 completes in one cycle with zero results and err=1).
// Ports:
//   clk     : clock, all state on posedge
//   reset_n : asynchronous active-low reset
//   bus     : tos_seq_alu_if.slave (request, results, busy/done/err, state)
module tos_seq_alu
  import tos_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  tos_seq_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic                 err_q, err_d;

  logic [2*WIDTH-1:0]   acc_step;
  op_e                  req_op;
  logic [SH_W-1:0]      req_n;
  logic                 req_skip;
  logic                 shift_zero;

  tos_seq_step #(.WIDTH(WIDTH)) u_step (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .mcand_i   (a_q),
    .divisor_i (b_q),
    .acc_o     (acc_step)
  );

  assign req_op = op_e'(bus.op);
  assign req_n  = bus.TOS[SH_W-1:0];

  // Divide-by-zero and the disabled divider go straight to FIN.
`ifdef TOS_SEQ_ALU_DIV_EN
  assign req_skip = (req_op == OP_UDIVMOD) && (bus.TOS == '0);
`else
  assign req_skip = (req_op == OP_UDIVMOD);
`endif

  // A zero shift still spends one RUN cycle but must leave the value alone.
  assign shift_zero = (b_q[SH_W-1:0] == '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lo_d    = lo_q;
    hi_d    = hi_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d   = req_op;
          a_d    = bus.arg;
          b_d    = bus.TOS;
          acc_d  = {{WIDTH{1'b0}}, (req_op == OP_UMUL) ? bus.TOS : bus.arg};
          busy_d = 1'b1;
          if (req_op == OP_SHL || req_op == OP_ASHR)
            cnt_d = (req_n == '0) ? CNT_W'(1) : {1'b0, req_n};
          else
            cnt_d = CNT_W'(WIDTH);
          state_d = req_skip ? ST_FIN : ST_RUN;
        end
      end

      ST_RUN: begin
        if (!((op_q == OP_SHL || op_q == OP_ASHR) && shift_zero))
          acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        case (op_q)
          OP_UMUL: begin
            lo_d  = acc_q[WIDTH-1:0];
            hi_d  = acc_q[2*WIDTH-1:WIDTH];
            err_d = 1'b0;
          end
          OP_UDIVMOD: begin
`ifdef TOS_SEQ_ALU_DIV_EN
            if (b_q == '0) begin
              lo_d  = '1;
              hi_d  = a_q;
              err_d = 1'b1;
            end else begin
              lo_d  = acc_q[WIDTH-1:0];
              hi_d  = acc_q[2*WIDTH-1:WIDTH];
              err_d = 1'b0;
            end
`else
            lo_d  = '0;
            hi_d  = '0;
            err_d = 1'b1;
`endif
          end
          default: begin
            lo_d  = acc_q[WIDTH-1:0];
            hi_d  = '0;
            err_d = 1'b0;
          end
        endcase
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_UMUL;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.err       = err_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_tos_seq_alu.sv
// Bench for tos_seq_alu (WIDTH=16). Build with and without
// TOS_SEQ_ALU_DIV_EN; expected divider results follow the same macro.
module tb_tos_seq_alu;
  import tos_alu_pkg::*;

  localparam int W = 16;

  logic clk;
  logic reset_n;

  tos_seq_alu_if #(.WIDTH(W)) bus ();

  tos_seq_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected {err, hi, lo} and latency, pushed at drive time
  logic [2*W:0] exp_q[$];
  int           lat_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] t);
    logic [2*W-1:0]      p;
    logic signed [W-1:0] s;
    logic [W-1:0]        r;
    model = '0;
    case (op)
      2'b00: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, t};
        model = {1'b0, p};
      end
      2'b01: begin
`ifdef TOS_SEQ_ALU_DIV_EN
        if (t == 0) model = {1'b1, a, {W{1'b1}}};
        else        model = {1'b0, a % t, a / t};
`else
        model = {1'b1, {(2*W){1'b0}}};
`endif
      end
      2'b10: begin
        r = a << t[3:0];
        model = {1'b0, {W{1'b0}}, r};
      end
      default: begin
        s = a;
        r = s >>> t[3:0];
        model = {1'b0, {W{1'b0}}, r};
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] t);
    int n;
    n = int'(t[3:0]);
    case (op)
      2'b00: model_lat = W + 1;
`ifdef TOS_SEQ_ALU_DIV_EN
      2'b01: model_lat = (t == 0) ? 1 : W + 1;
`else
      2'b01: model_lat = 1;
`endif
      default: model_lat = ((n == 0) ? 1 : n) + 1;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic scramble_inputs();
    bus.op  = 2'($urandom_range(0, 3));
    bus.arg = W'($urandom);
    bus.TOS = W'($urandom);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] t,
                        input logic [2*W:0] want, input int want_lat, input bit hammer);
    int           edges;
    int           extra;
    bit           got;
    bit           busy_ok;
    logic [2*W:0] e;
    int           l;
    exp_q.push_back(want);
    lat_q.push_back(want_lat);
    @(negedge clk);
    bus.op = op; bus.arg = a; bus.TOS = t; bus.start = 1'b1;
    @(posedge clk); #1;                 // accepting edge (edge 0)
    edges   = 0;
    got     = 1'b0;
    busy_ok = bus.busy;
    if (!hammer) bus.start = 1'b0;
    scramble_inputs();
    while (!got && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (bus.done) begin
        got = 1'b1;
        bus.start = 1'b0;
      end else begin
        if (!bus.busy) busy_ok = 1'b0;
        if (hammer) scramble_inputs();
      end
    end
    check("timeout", {63'd0, got}, 64'd1);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (got) begin
      check("latency", 64'(edges), 64'(l));
      check("lo",  64'(bus.result_lo), 64'(e[W-1:0]));
      check("hi",  64'(bus.result_hi), 64'(e[2*W-1:W]));
      check("err", 64'(bus.err), 64'(e[2*W]));
      check("busy_at_done", 64'(bus.busy), 64'd0);
      check("busy_run", 64'(busy_ok), 64'd1);
      @(posedge clk); #1;
      check("done_pulse", 64'(bus.done), 64'd0);
      check("lo_hold", 64'(bus.result_lo), 64'(e[W-1:0]));
      check("hi_hold", 64'(bus.result_hi), 64'(e[2*W-1:W]));
      check("state_idle", 64'(bus.state), 64'(ST_IDLE));
      if (hammer) begin
        extra = 0;
        repeat (20) begin
          @(posedge clk); #1;
          if (bus.done) extra++;
        end
        check("extra_done", 64'(extra), 64'd0);
      end
    end
  endtask

  task automatic run_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] t);
    run_op(op, a, t, model(op, a, t), model_lat(op, t), 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_lo"},   64'(bus.result_lo), 64'd0);
    check({tag, "_hi"},   64'(bus.result_hi), 64'd0);
    check({tag, "_err"},  64'(bus.err), 64'd0);
    check({tag, "_state"}, 64'(bus.state), 64'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rt;
    int           aborted_done;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.arg   = '0;
    bus.TOS   = '0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // UMUL
    run_op(2'b00, 16'h1234, 16'h0010, {1'b0, 16'h0001, 16'h2340}, 17, 1'b0);
    run_op(2'b00, 16'hFFFF, 16'hFFFF, {1'b0, 16'hFFFE, 16'h0001}, 17, 1'b0);

    // UDIVMOD, then divide by zero
`ifdef TOS_SEQ_ALU_DIV_EN
    run_op(2'b01, 16'd100, 16'd7, {1'b0, 16'd2, 16'd14}, 17, 1'b0);
    run_op(2'b01, 16'h00AB, 16'h0000, {1'b1, 16'h00AB, 16'hFFFF}, 1, 1'b0);
`else
    run_op(2'b01, 16'd100, 16'd7, {1'b1, 16'h0000, 16'h0000}, 1, 1'b0);
    run_op(2'b01, 16'h00AB, 16'h0000, {1'b1, 16'h0000, 16'h0000}, 1, 1'b0);
`endif

    // shifts, including zero amount and amount taken from low bits only
    run_op(2'b11, 16'h8000, 16'h0003, {1'b0, 16'h0000, 16'hF000}, 4, 1'b0);
    run_op(2'b10, 16'h0001, 16'h0000, {1'b0, 16'h0000, 16'h0001}, 2, 1'b0);
    run_op(2'b10, 16'h0001, 16'h000F, {1'b0, 16'h0000, 16'h8000}, 16, 1'b0);
    run_op(2'b11, 16'h4000, 16'h0013, {1'b0, 16'h0000, 16'h0800}, 4, 1'b0);

    // start held every cycle during a UMUL: one done, first op's results
    run_op(2'b00, 16'h00FF, 16'h0101, {1'b0, 16'h0000, 16'hFFFF}, 17, 1'b1);

    // random mix against the model
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom);
      rt  = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      run_model(rop, ra, rt);
    end

    // reset mid-operation aborts with no done pulse
    @(negedge clk);
    bus.op = 2'b00; bus.arg = 16'h0F0F; bus.TOS = 16'h00F1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    aborted_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done) aborted_done++;
    end
    reset_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.done) aborted_done++;
    end
    check("abort_done", 64'(aborted_done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(2'b00, 16'h0F0F, 16'h00F1, model(2'b00, 16'h0F0F, 16'h00F1), 17, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
